// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter (optional retry: PS2_TX_RETRY_EN)
module ps2_host_tx #(
  parameter int INHIBIT_CYC = 5000,
  parameter int TIMEOUT_CYC = 750000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int IW = $clog2(INHIBIT_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IW-1:0] INH_PRE  = IW'(INHIBIT_CYC - 2);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYC - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

`ifdef PS2_TX_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_DATA, S_ACK, S_WAIT_IDLE, S_DONE
  } state_t;

  state_t          state, state_n;
  logic [IW-1:0]   inh_cnt, inh_n;
  logic [TW-1:0]   to_cnt, to_n;
  logic [3:0]      bit_cnt, bit_cnt_n;
  logic [7:0]      tx_byte, tx_byte_n;
  logic            parity_q, parity_n;
  logic            attempt, attempt_n;
  logic            clk_oe_q, clk_oe_n;
  logic            data_oe_q, data_oe_n;
  logic            done_q, done_n;
  logic            err_q, err_n;
  logic            ready_q, ready_n;
  logic            retry_ok;

  logic clk_m, clk_s, clk_d, data_m, data_s;
  logic fall;

  assign fall = clk_d & ~clk_s;

  // Two-flop synchronizers for both pins plus a delayed copy of ps2_clk for edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_m  <= 1'b1;
      clk_s  <= 1'b1;
      clk_d  <= 1'b1;
      data_m <= 1'b1;
      data_s <= 1'b1;
    end else begin
      clk_m  <= ps2_clk_in;
      clk_s  <= clk_m;
      clk_d  <= clk_s;
      data_m <= ps2_data_in;
      data_s <= data_m;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      inh_cnt   <= '0;
      to_cnt    <= '0;
      bit_cnt   <= '0;
      tx_byte   <= '0;
      parity_q  <= 1'b0;
      attempt   <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state     <= state_n;
      inh_cnt   <= inh_n;
      to_cnt    <= to_n;
      bit_cnt   <= bit_cnt_n;
      tx_byte   <= tx_byte_n;
      parity_q  <= parity_n;
      attempt   <= attempt_n;
      clk_oe_q  <= clk_oe_n;
      data_oe_q <= data_oe_n;
      done_q    <= done_n;
      err_q     <= err_n;
      ready_q   <= ready_n;
    end
  end

  // Next-state and next-output logic; a detected fall always takes priority over timeout expiry.
  always_comb begin
    state_n   = state;
    inh_n     = inh_cnt;
    to_n      = to_cnt;
    bit_cnt_n = bit_cnt;
    tx_byte_n = tx_byte;
    parity_n  = parity_q;
    attempt_n = attempt;
    clk_oe_n  = clk_oe_q;
    data_oe_n = data_oe_q;
    done_n    = 1'b0;
    err_n     = err_q;
    ready_n   = ready_q;
    retry_ok  = RETRY_EN & ~attempt;

    case (state)
      S_IDLE: begin
        if (tx_valid && ready_q) begin
          tx_byte_n = tx_data;
          parity_n  = ~^tx_data;
          ready_n   = 1'b0;
          err_n     = 1'b0;
          attempt_n = 1'b0;
          inh_n     = '0;
          clk_oe_n  = 1'b1;
          data_oe_n = 1'b0;
          state_n   = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        inh_n = inh_cnt + IW'(1);
        // Start bit goes low one cycle before the clock is released.
        if (inh_cnt == INH_PRE) begin
          data_oe_n = 1'b1;
        end
        if (inh_cnt == INH_LAST) begin
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b1;
          to_n      = '0;
          bit_cnt_n = '0;
          state_n   = S_RTS;
        end
      end

      S_RTS, S_DATA, S_ACK: begin
        to_n = to_cnt + TW'(1);
        if (fall) begin
          if (state == S_ACK) begin
            err_n   = data_s;
            state_n = S_WAIT_IDLE;
          end else begin
            bit_cnt_n = bit_cnt + 4'd1;
            state_n   = S_DATA;
            if (bit_cnt < 4'd8) begin
              data_oe_n = ~tx_byte[bit_cnt[2:0]];
            end else if (bit_cnt == 4'd8) begin
              data_oe_n = ~parity_q;
            end else begin
              data_oe_n = 1'b0;
              state_n   = S_ACK;
            end
          end
        end else if (to_cnt == TMO_LAST) begin
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b0;
          if (retry_ok) begin
            attempt_n = 1'b1;
            inh_n     = '0;
            clk_oe_n  = 1'b1;
            state_n   = S_INHIBIT;
          end else begin
            err_n   = 1'b1;
            done_n  = 1'b1;
            state_n = S_DONE;
          end
        end
      end

      S_WAIT_IDLE: begin
        // The device must release both lines before the next attempt or completion.
        if (clk_s && data_s) begin
          if (err_q && retry_ok) begin
            attempt_n = 1'b1;
            err_n     = 1'b0;
            inh_n     = '0;
            clk_oe_n  = 1'b1;
            data_oe_n = 1'b0;
            state_n   = S_INHIBIT;
          end else begin
            done_n  = 1'b1;
            state_n = S_DONE;
          end
        end
      end

      S_DONE: begin
        ready_n = 1'b1;
        state_n = S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase
  end

  assign tx_ready    = ready_q;
  assign busy        = ~ready_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a behavioural PS/2 device
module tb_ps2_host_tx;

  localparam int INH  = 200;
  localparam int TMO  = 2000;
  localparam int HALF = 20;
`ifdef PS2_TX_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, busy, done, err, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       dev_abort = 1'b0;
  logic       ps2_clk_line, ps2_data_line;

  int checks = 0;
  int failures = 0;
  int done_count = 0;
  int dev_falls = 0;

  assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO)) dut (
    .clock       (clock),
    .reset       (reset),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .ps2_clk_in  (ps2_clk_line),
    .ps2_data_in (ps2_data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #10 clock = ~clock;

  always @(negedge clock) if (done === 1'b1) done_count++;

  // Expected line frame: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] frame(input logic [7:0] b);
    int ones;
    logic [10:0] f;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = b[i];
      ones += int'(b[i]);
    end
    f[9]  = (ones % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic dwait(input int n);
    for (int k = 0; k < n && !dev_abort; k++) @(negedge clock);
  endtask

  task automatic device_xfer(input int half, input bit ack, input bit clocked,
                             output logic [10:0] bits, output int inh, output int ovl);
    int t;
    bits = '1; inh = 0; ovl = 0; dev_falls = 0; t = 0;
    while (ps2_clk_oe !== 1'b1 && t < 5000) begin @(negedge clock); t++; end
    while (ps2_clk_oe === 1'b1 && inh < 5000) begin
      inh++;
      if (ps2_data_oe === 1'b1) ovl++;
      @(negedge clock);
    end
    bits[0] = ps2_data_line;
    if (clocked) begin
      for (int i = 1; i <= 10 && !dev_abort; i++) begin
        dwait(half); dev_clk_low = 1'b1; dev_falls++;
        dwait(half); dev_clk_low = 1'b0;
        bits[i] = ps2_data_line;
      end
      if (!dev_abort) begin
        dwait(half / 2); dev_data_low = ack;
        dwait(half - half / 2); dev_clk_low = 1'b1; dev_falls++;
        dwait(half); dev_clk_low = 1'b0;
        dwait(4); dev_data_low = 1'b0;
      end
    end
    dev_clk_low = 1'b0;
    dev_data_low = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    while (tx_ready !== 1'b1 && t < 5000) begin @(negedge clock); t++; end
    tx_valid = 1'b1; tx_data = b;
    @(negedge clock);
    tx_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit got, output bit e);
    int c;
    c = 0;
    while (done !== 1'b1 && c < budget) begin @(negedge clock); c++; end
    got = (done === 1'b1);
    e = err;
  endtask

  task automatic xfer(input logic [7:0] b, input int half, input bit ack,
                      output logic [10:0] bits, output int inh, output int ovl,
                      output bit got, output bit e, output int pulses);
    int base;
    base = done_count;
    send_byte(b);
    fork
      begin
        device_xfer(half, ack, 1'b1, bits, inh, ovl);
        if (!ack && RETRY) device_xfer(half, 1'b1, 1'b1, bits, inh, ovl);
      end
      wait_done(20000, got, e);
    join
    @(negedge clock);
    pulses = done_count - base;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (ps2_clk_oe !== 1'b0) begin failures++; $display("FAIL reset_clk_oe got=%b exp=0", ps2_clk_oe); end
    checks++; if (ps2_data_oe !== 1'b0) begin failures++; $display("FAIL reset_data_oe got=%b exp=0", ps2_data_oe); end
    reset = 1'b0;
    repeat (5) @(negedge clock);
  endtask

  task automatic test_enable_f4();
    logic [10:0] bits, exp_f;
    int inh, ovl, pulses;
    bit got, e;
    exp_f = frame(8'hF4);
    xfer(8'hF4, HALF, 1'b1, bits, inh, ovl, got, e, pulses);
    checks++; if (inh != INH) begin failures++; $display("FAIL f4_inhibit_len got=%0d exp=%0d", inh, INH); end
    checks++; if (ovl != 1) begin failures++; $display("FAIL f4_start_overlap got=%0d exp=1", ovl); end
    checks++; if (bits !== exp_f) begin failures++; $display("FAIL f4_frame got=%b exp=%b", bits, exp_f); end
    checks++; if (!got || e !== 1'b0) begin failures++; $display("FAIL f4_done got=%b err=%b exp done=1 err=0", got, e); end
    checks++; if (pulses != 1) begin failures++; $display("FAIL f4_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_parity_ff();
    logic [10:0] bits, exp_f;
    int inh, ovl, pulses;
    bit got, e;
    exp_f = frame(8'hFF);
    xfer(8'hFF, HALF, 1'b1, bits, inh, ovl, got, e, pulses);
    checks++; if (bits[9] !== exp_f[9]) begin failures++; $display("FAIL ff_parity got=%b exp=%b", bits[9], exp_f[9]); end
    checks++; if (bits !== exp_f) begin failures++; $display("FAIL ff_frame got=%b exp=%b", bits, exp_f); end
    checks++; if (!got || e !== 1'b0) begin failures++; $display("FAIL ff_done got=%b err=%b exp done=1 err=0", got, e); end
    checks++; if (tx_ready !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL ff_ready_after_done ready=%b done=%b exp 1 0", tx_ready, done); end
  endtask

  task automatic test_nack_ed();
    logic [10:0] bits, exp_f;
    int inh, ovl, pulses;
    bit got, e, exp_e;
    exp_f = frame(8'hED);
    exp_e = !RETRY;
    xfer(8'hED, HALF, 1'b0, bits, inh, ovl, got, e, pulses);
    checks++; if (bits !== exp_f) begin failures++; $display("FAIL ed_frame got=%b exp=%b", bits, exp_f); end
    checks++; if (!got || e !== exp_e) begin failures++; $display("FAIL ed_err got=%b err=%b exp done=1 err=%b", got, e, exp_e); end
    checks++; if (pulses != 1) begin failures++; $display("FAIL ed_pulses got=%0d exp=1", pulses); end
    checks++; if (inh != INH) begin failures++; $display("FAIL ed_inhibit_len got=%0d exp=%0d", inh, INH); end
  endtask

  task automatic test_timeout();
    logic [10:0] bits;
    int inh, ovl, hold, base;
    bit got, e;
    base = done_count;
    send_byte(8'h3C);
    device_xfer(HALF, 1'b1, 1'b0, bits, inh, ovl);
    hold = 0;
    while (ps2_data_oe === 1'b1 && hold < TMO + 100) begin hold++; @(negedge clock); end
    checks++; if (bits[0] !== 1'b0) begin failures++; $display("FAIL to_start_bit got=%b exp=0", bits[0]); end
    checks++; if (hold != TMO) begin failures++; $display("FAIL to_release got=%0d exp=%0d", hold, TMO); end
    wait_done(10000, got, e);
    checks++; if (!got || e !== 1'b1) begin failures++; $display("FAIL to_done got=%b err=%b exp done=1 err=1", got, e); end
    checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin failures++; $display("FAIL to_lines clk_oe=%b data_oe=%b exp 0 0", ps2_clk_oe, ps2_data_oe); end
    @(negedge clock);
    checks++; if (done_count - base != 1) begin failures++; $display("FAIL to_pulses got=%0d exp=1", done_count - base); end
  endtask

  task automatic test_reset_mid();
    logic [10:0] bits, exp_f;
    int inh, ovl, base, t, pulses;
    bit got, e;
    dev_abort = 1'b0;
    base = done_count;
    send_byte(8'hF4);
    fork
      device_xfer(HALF, 1'b1, 1'b1, bits, inh, ovl);
      begin
        t = 0;
        while (dev_falls < 5 && t < 3000) begin @(negedge clock); t++; end
        checks++; if (dev_falls < 5) begin failures++; $display("FAIL rm_reach_edge5 got=%0d exp=5", dev_falls); end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx_ready !== 1'b1) begin
          failures++; $display("FAIL rm_after_reset clk_oe=%b data_oe=%b ready=%b exp 0 0 1", ps2_clk_oe, ps2_data_oe, tx_ready);
        end
        dev_abort = 1'b1;
      end
    join
    dev_abort = 1'b0;
    repeat (50) @(negedge clock);
    checks++; if (done_count != base) begin failures++; $display("FAIL rm_no_done got=%0d exp=%0d", done_count, base); end
    exp_f = frame(8'hF4);
    xfer(8'hF4, HALF, 1'b1, bits, inh, ovl, got, e, pulses);
    checks++; if (bits !== exp_f || !got || e !== 1'b0) begin failures++; $display("FAIL rm_resend frame=%b exp=%b done=%b err=%b", bits, exp_f, got, e); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] b1, b2, exp1, exp2;
    int inh1, inh2, ovl, t;
    bit got1, got2, e1, e2;
    exp1 = frame(8'h55);
    exp2 = frame(8'hAA);
    t = 0;
    while (tx_ready !== 1'b1 && t < 5000) begin @(negedge clock); t++; end
    tx_valid = 1'b1; tx_data = 8'h55;
    @(negedge clock);
    tx_data = 8'hAA;
    fork
      device_xfer(HALF, 1'b1, 1'b1, b1, inh1, ovl);
      wait_done(20000, got1, e1);
    join
    fork
      device_xfer(HALF, 1'b1, 1'b1, b2, inh2, ovl);
      begin
        t = 0;
        while (tx_ready !== 1'b1 && t < 100) begin @(negedge clock); t++; end
        while (tx_ready === 1'b1 && t < 100) begin @(negedge clock); t++; end
        tx_valid = 1'b0;
      end
    join
    wait_done(20000, got2, e2);
    @(negedge clock);
    checks++; if (b1 !== exp1 || inh1 != INH) begin failures++; $display("FAIL b2b_first frame=%b exp=%b inh=%0d", b1, exp1, inh1); end
    checks++; if (!got1 || e1 !== 1'b0) begin failures++; $display("FAIL b2b_first_done got=%b err=%b exp 1 0", got1, e1); end
    checks++; if (b2 !== exp2 || !got2 || e2 !== 1'b0) begin failures++; $display("FAIL b2b_second frame=%b exp=%b done=%b err=%b", b2, exp2, got2, e2); end
  endtask

  task automatic test_random();
    logic [10:0] bits, exp_f;
    logic [7:0] b;
    int inh, ovl, pulses, half;
    bit got, e, ack, exp_e;
    for (int n = 0; n < 6; n++) begin
      b = 8'($urandom);
      half = $urandom_range(8, 24);
      ack = ($urandom_range(0, 2) != 0);
      exp_f = frame(b);
      exp_e = !ack && !RETRY;
      xfer(b, half, ack, bits, inh, ovl, got, e, pulses);
      checks++; if (bits !== exp_f) begin failures++; $display("FAIL rnd_frame byte=%h got=%b exp=%b", b, bits, exp_f); end
      checks++; if (!got || e !== exp_e || pulses != 1) begin
        failures++; $display("FAIL rnd_done byte=%h ack=%b done=%b err=%b pulses=%0d exp err=%b pulses=1", b, ack, got, e, pulses, exp_e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_enable_f4();
    test_parity_ff();
    test_nack_ed();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
